instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/ifu_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 56 +++++
 rtl/instruction_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   - ifu_state_e     : fetch FSM states (IDLE / WAIT / DROP)
//   - RESET_PC_DEFAULT: default first fetch address after reset
//   - INSTR_W, ADDR_W : instruction word and byte-address widths
//   - word_align()    : clears the two byte-offset bits of an address
package ifu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request outstanding
    ST_WAIT = 2'd1,  // waiting for the response to our request
    ST_DROP = 2'd2   // waiting for a stale response that must be discarded
  } ifu_state_e;

  // Masking (rather than slicing) keeps every input bit referenced.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous circular FIFO holding fetched {pc, instr} pairs.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (empties the queue)
//   push, push_data - write an entry at the tail
//   pop             - remove the head entry (ignored when empty)
//   flush           - empty the queue; overrides push and pop
//   head_data       - head entry, forced to zero while empty
//   full, empty     - occupancy flags
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: sequential instruction fetcher with a small
// instruction queue toward decode and branch/jump redirect support.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   imem_req, imem_addr         - single-cycle fetch request and word address
//   imem_rvalid, imem_rdata     - one response per request
//   redirect_valid, redirect_pc - flush and restart fetch at redirect_pc
//   if_valid, if_ready          - decode handshake on the queue head
//   if_instr, if_pc             - head instruction word and its address
//   dbg_state                   - current fetch FSM state (ifu_state_e encoding)
//
// Decode handshake: an entry is transferred on a rising edge where
// if_valid && if_ready. if_valid never depends on if_ready, and the head
// (if_instr/if_pc) holds stable while if_valid && !if_ready. A redirect in
// the same cycle still completes the transfer, then flushes the rest.
module instruction_fetch_unit import ifu_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [1:0]         dbg_state
);

  localparam int QW = ADDR_W + INSTR_W;

  ifu_state_e        state;
  ifu_state_e        state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_nxt;
  logic              issue;
  logic              q_push;
  logic              q_flush;
  logic              q_full;
  logic              q_empty;
  logic [QW-1:0]     q_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    issue        = 1'b0;
    q_push       = 1'b0;
    q_flush      = 1'b0;
    case (state)
      ST_IDLE: begin
        // A redirect suppresses issue so we never fetch the stale fetch_pc.
        if (redirect_valid) begin
          q_flush      = 1'b1;
          fetch_pc_nxt = word_align(redirect_pc);
        end else if (!q_full) begin
          issue     = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          // Redirect wins over a coincident response, which is then dropped.
          q_flush      = 1'b1;
          fetch_pc_nxt = word_align(redirect_pc);
          state_nxt    = imem_rvalid ? ST_IDLE : ST_DROP;
        end else if (imem_rvalid) begin
          q_push       = 1'b1;
          fetch_pc_nxt = fetch_pc + ADDR_W'(4);
          state_nxt    = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          q_flush      = 1'b1;
          fetch_pc_nxt = word_align(redirect_pc);
        end
        if (imem_rvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (QW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ({fetch_pc, imem_rdata}),
    .pop       (if_ready),
    .flush     (q_flush),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // imem_req is gated by reset so nothing is requested while held in reset.
  assign imem_req  = issue && !reset;
  assign imem_addr = fetch_pc;
  assign if_valid  = !q_empty;
  assign if_pc     = q_head[QW-1:INSTR_W];
  assign if_instr  = q_head[INSTR_W-1:0];
  assign dbg_state = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed bench for instruction_fetch_unit with a
// latency-programmable instruction memory model (word = {16'hC0DE, addr[15:0]}).
module tb_instruction_fetch_unit;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [1:0]  dbg_state;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int          checks    = 0;
  int          failures  = 0;
  int          proto_err = 0;
  int          mem_lat   = 1;
  int          mem_cnt;
  logic        mem_busy;
  logic [31:0] mem_addr;
  logic [31:0] req_log[$];
  logic [63:0] acc_log[$];
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compares accepted decode transfers, in order, against the expected queue.
  task automatic sb_drain(input string tag);
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      if (acc_log.size() == 0) check({tag, "_missing"}, 64'hFFFF_FFFF_FFFF_FFFF, e);
      else                     check(tag, acc_log.pop_front(), e);
    end
  endtask

  // ---------------- memory model and monitors ----------------
  // Runs 1 time unit after each falling edge, after the main thread drives.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    mem_busy    = 1'b0;
    mem_cnt     = 0;
    mem_addr    = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (reset) begin
        mem_busy = 1'b0;
      end else begin
        if (mem_busy) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = {16'hC0DE, mem_addr[15:0]};
            mem_busy    = 1'b0;
          end
        end
        if (imem_req) begin
          if (mem_busy) proto_err++;
          mem_busy = 1'b1;
          mem_cnt  = mem_lat;
          mem_addr = imem_addr;
          req_log.push_back(imem_addr);
        end
        if (if_valid && if_ready) acc_log.push_back({if_pc, if_instr});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input int lat);
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    mem_lat        = lat;
    repeat (2) @(negedge clk);
    req_log.delete();
    acc_log.delete();
    exp_q.delete();
  endtask

  task automatic release_reset(input logic ready);
    @(negedge clk);
    reset          = 1'b0;
    if_ready       = ready;
    redirect_valid = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;

    // Reset values
    apply_reset(1);
    #2;
    check("rst_req",   imem_req,  0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", if_valid,  0);
    check("rst_instr", if_instr,  32'h0);
    check("rst_pc",    if_pc,     32'h0);
    check("rst_state", dbg_state, S_IDLE);

    // Streaming, latency 1, decode always ready
    release_reset(1'b1);
    #2;
    check("first_req",  imem_req,  1);
    check("first_addr", imem_addr, 32'h0);
    repeat (9) @(negedge clk);
    check("stream_req0", req_log[0], 32'h0);
    check("stream_req1", req_log[1], 32'h4);
    check("stream_req2", req_log[2], 32'h8);
    exp_q.push_back(64'h0000_0000_C0DE_0000);
    exp_q.push_back(64'h0000_0004_C0DE_0004);
    exp_q.push_back(64'h0000_0008_C0DE_0008);
    sb_drain("stream_acc");

    // Backpressure: queue fills to two entries, head holds, then drains
    apply_reset(1);
    release_reset(1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      #2;
      if (k >= 4) check("stall_head", {if_pc, if_instr}, 64'h0000_0000_C0DE_0000);
    end
    check("stall_req_when_full", imem_req, 0);
    check("stall_req_count", req_log.size(), 2);
    check("stall_no_accept", acc_log.size(), 0);
    @(negedge clk);
    if_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("drain_req2", req_log[2], 32'h8);
    exp_q.push_back(64'h0000_0000_C0DE_0000);
    exp_q.push_back(64'h0000_0004_C0DE_0004);
    exp_q.push_back(64'h0000_0008_C0DE_0008);
    sb_drain("drain_acc");

    // Redirect while waiting on 0x8 (latency 3): response dropped
    apply_reset(3);
    release_reset(1'b1);
    repeat (8) @(negedge clk);
    #2;
    check("wait8_req",  imem_req,  1);
    check("wait8_addr", imem_addr, 32'h8);
    @(negedge clk);
    redirect(32'h0000_0103);
    #2;
    check("wait8_state", dbg_state, S_WAIT);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("drop_state", dbg_state, S_DROP);
    check("drop_no_req", imem_req, 0);
    @(negedge clk);
    #2;
    check("drop_hold", dbg_state, S_DROP);
    @(negedge clk);
    #2;
    check("redir_state", dbg_state, S_IDLE);
    check("redir_req",   imem_req,  1);
    check("redir_addr",  imem_addr, 32'h100);
    repeat (5) @(negedge clk);
    exp_q.push_back(64'h0000_0000_C0DE_0000);
    exp_q.push_back(64'h0000_0004_C0DE_0004);
    exp_q.push_back(64'h0000_0100_C0DE_0100);
    sb_drain("redir_acc");
    check("redir_extra", acc_log.size(), 0);

    // Redirect coincident with response, then redirect during a handshake
    apply_reset(1);
    release_reset(1'b1);
    @(negedge clk);
    redirect(32'h0000_0200);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("coin_state", dbg_state, S_IDLE);
    check("coin_valid", if_valid,  0);
    check("coin_req",   imem_req,  1);
    check("coin_addr",  imem_addr, 32'h200);
    repeat (2) @(negedge clk);
    redirect(32'h0000_0302);
    #2;
    check("hs_head", {if_pc, if_instr}, 64'h0000_0200_C0DE_0200);
    check("hs_no_req", imem_req, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("hs_flushed", if_valid,  0);
    check("hs_req",     imem_req,  1);
    check("hs_addr",    imem_addr, 32'h300);
    exp_q.push_back(64'h0000_0200_C0DE_0200);
    sb_drain("hs_acc");
    check("hs_extra", acc_log.size(), 0);

    // Reset asserted mid-WAIT (latency 3)
    apply_reset(3);
    release_reset(1'b1);
    redirect(32'h0000_0040);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("mrst_pre_addr", imem_addr, 32'h40);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("mrst_wait", dbg_state, S_WAIT);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("mrst_state", dbg_state, S_IDLE);
    check("mrst_valid", if_valid,  0);
    check("mrst_pc",    if_pc,     32'h0);
    check("mrst_req",   imem_req,  1);
    check("mrst_addr",  imem_addr, 32'h0);
    repeat (5) @(negedge clk);
    check("mrst_req_log", req_log[1], 32'h0);
    exp_q.push_back(64'h0000_0000_C0DE_0000);
    sb_drain("mrst_acc");

    // Address wrap from 0xFFFF_FFFC, redirect offset bits ignored
    apply_reset(1);
    release_reset(1'b1);
    redirect(32'hFFFF_FFFF);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("wrap_req",  imem_req,  1);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    repeat (2) @(negedge clk);
    #2;
    check("wrap_head",      {if_pc, if_instr}, 64'hFFFF_FFFC_C0DE_FFFC);
    check("wrap_next_req",  imem_req,  1);
    check("wrap_next_addr", imem_addr, 32'h0);

    check("one_outstanding", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
